// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD message scheduler: FSM state encoding,
// HD44780-style instruction bytes and ASCII constants used by the ROM.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_ADR1,
        ST_L1,
        ST_ADR2,
        ST_L2,
        ST_FIN
    } state_t;

    localparam logic [7:0] LCD_CLEAR     = 8'h01;
    localparam logic [7:0] LCD_SET_DDRAM = 8'h80;
    localparam logic [7:0] ASCII_0       = 8'h30;
    localparam logic [7:0] ASCII_SP      = 8'h20;

    localparam logic [3:0] SCORE_MAX     = 4'd9;

endpackage

// File: rtl/lcd_msg_rom.sv
// Message text ROM: maps (grant, line, character index, win counts) to the
// ASCII byte shown at that position. Line 1 is "PLAYER n WINS!  ", line 2 is
// "P1:a  P2:b      ".
module lcd_msg_rom
    import lcd_pkg::*;
(
    input  logic [1:0] grant,
    input  logic       line,
    input  logic [3:0] idx,
    input  logic [3:0] p1_cnt,
    input  logic [3:0] p2_cnt,
    output logic [7:0] ch
);

    // Character lookup for the selected line and column
    always_comb begin
        ch = ASCII_SP;
        if (!line) begin
            case (idx)
                4'd0:    ch = "P";
                4'd1:    ch = "L";
                4'd2:    ch = "A";
                4'd3:    ch = "Y";
                4'd4:    ch = "E";
                4'd5:    ch = "R";
                4'd7:    ch = (grant == 2'b10) ? "2" : "1";
                4'd9:    ch = "W";
                4'd10:   ch = "I";
                4'd11:   ch = "N";
                4'd12:   ch = "S";
                4'd13:   ch = "!";
                default: ch = ASCII_SP;
            endcase
        end else begin
            case (idx)
                4'd0:    ch = "P";
                4'd1:    ch = "1";
                4'd2:    ch = ":";
                4'd3:    ch = ASCII_0 + {4'b0000, p1_cnt};
                4'd6:    ch = "P";
                4'd7:    ch = "2";
                4'd8:    ch = ":";
                4'd9:    ch = ASCII_0 + {4'b0000, p2_cnt};
                default: ch = ASCII_SP;
            endcase
        end
    end

endmodule

// File: rtl/lcd_msg_scheduler.sv
// LCD win-message scheduler: edge-detects the active-low player win inputs,
// latches pending requests, grants them round-robin and streams clear,
// cursor-address and line text as valid/ready command transfers.
// Optional macro LCD_SCHED_SCORE_EN adds saturating win counters and a
// second line showing the score.
module lcd_msg_scheduler
    import lcd_pkg::*;
#(
    parameter int unsigned LINE_LEN   = 16,
    parameter logic [6:0]  LINE1_ADDR = 7'h00,
    parameter logic [6:0]  LINE2_ADDR = 7'h40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       p1win,
    input  logic       p2win,
    output logic       cmd_valid,
    output logic       cmd_rs,
    output logic [7:0] cmd_data,
    input  logic       cmd_rdy,
    output logic       busy,
    output logic [1:0] grant,
    output logic       done
);

    localparam logic [3:0] IDX_LAST = 4'(LINE_LEN - 1);

    state_t     state_q, state_d;
    logic [1:0] win_cur_q, win_cur_d;
    logic [1:0] win_prev_q, win_prev_d;
    logic [1:0] pend_q, pend_d;
    logic [1:0] pend_clr;
    logic       ptr_q, ptr_d;
    logic       sel;
    logic [3:0] idx_q, idx_d;
    logic [1:0] grant_q, grant_d;
    logic [1:0] win_ev;
    logic [3:0] p1_cnt, p2_cnt;
    logic [7:0] rom_ch;

`ifdef LCD_SCHED_SCORE_EN
    logic [3:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;
    assign p1_cnt = cnt1_q;
    assign p2_cnt = cnt2_q;
`else
    assign p1_cnt = '0;
    assign p2_cnt = '0;
`endif

    // Input sampling and falling-edge detection
    always_comb begin
        win_cur_d  = {p2win, p1win};
        win_prev_d = win_cur_q;
        win_ev     = win_prev_q & ~win_cur_q;
    end

    lcd_msg_rom u_rom (
        .grant  (grant_q),
        .line   (state_q == ST_L2),
        .idx    (idx_q),
        .p1_cnt (p1_cnt),
        .p2_cnt (p2_cnt),
        .ch     (rom_ch)
    );

    // Next-state, arbitration and command output decode
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        pend_clr  = '0;
        sel       = 1'b0;
        cmd_valid = 1'b0;
        cmd_rs    = 1'b0;
        cmd_data  = '0;
`ifdef LCD_SCHED_SCORE_EN
        cnt1_d    = cnt1_q;
        cnt2_d    = cnt2_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|pend_q) begin
                    sel      = pend_q[ptr_q] ? ptr_q : ~ptr_q;
                    grant_d  = sel ? 2'b10 : 2'b01;
                    pend_clr = grant_d;
                    ptr_d    = ~sel;
                    state_d  = ST_CLR;
`ifdef LCD_SCHED_SCORE_EN
                    if (!sel && cnt1_q != SCORE_MAX) cnt1_d = cnt1_q + 4'd1;
                    if (sel && cnt2_q != SCORE_MAX)  cnt2_d = cnt2_q + 4'd1;
`endif
                end
            end
            ST_CLR: begin
                cmd_valid = 1'b1;
                cmd_data  = LCD_CLEAR;
                if (cmd_rdy) state_d = ST_ADR1;
            end
            ST_ADR1: begin
                cmd_valid = 1'b1;
                cmd_data  = LCD_SET_DDRAM | {1'b0, LINE1_ADDR};
                if (cmd_rdy) state_d = ST_L1;
            end
            ST_L1: begin
                cmd_valid = 1'b1;
                cmd_rs    = 1'b1;
                cmd_data  = rom_ch;
                if (cmd_rdy) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
`ifdef LCD_SCHED_SCORE_EN
                        state_d = ST_ADR2;
`else
                        state_d = ST_FIN;
`endif
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            ST_ADR2: begin
                cmd_valid = 1'b1;
                cmd_data  = LCD_SET_DDRAM | {1'b0, LINE2_ADDR};
                if (cmd_rdy) state_d = ST_L2;
            end
            ST_L2: begin
                cmd_valid = 1'b1;
                cmd_rs    = 1'b1;
                cmd_data  = rom_ch;
                if (cmd_rdy) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = ST_FIN;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            ST_FIN: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // A fresh event wins over the clear so a request during the owner's
        // grant cycle is not lost.
        pend_d = (pend_q & ~pend_clr) | win_ev;
    end

    assign busy  = (state_q != ST_IDLE);
    assign done  = (state_q == ST_FIN);
    assign grant = grant_q;

    // State and request registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            win_cur_q  <= '1;
            win_prev_q <= '1;
            pend_q     <= '0;
            ptr_q      <= 1'b0;
            idx_q      <= '0;
            grant_q    <= '0;
`ifdef LCD_SCHED_SCORE_EN
            cnt1_q     <= '0;
            cnt2_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            win_cur_q  <= win_cur_d;
            win_prev_q <= win_prev_d;
            pend_q     <= pend_d;
            ptr_q      <= ptr_d;
            idx_q      <= idx_d;
            grant_q    <= grant_d;
`ifdef LCD_SCHED_SCORE_EN
            cnt1_q     <= cnt1_d;
            cnt2_q     <= cnt2_d;
`endif
        end
    end

endmodule

// File: tb/tb_lcd_msg_scheduler.sv
// Self-checking bench for lcd_msg_scheduler: directed scenarios plus random
// win events and random cmd_rdy patterns, compared against a message-level
// reference model (expected byte stream built from the message text).
module tb_lcd_msg_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       p1win, p2win;
    logic       cmd_valid, cmd_rs, cmd_rdy;
    logic [7:0] cmd_data;
    logic       busy, done;
    logic [1:0] grant;

    int checks = 0;
    int errs   = 0;

    logic [10:0] got[$];
    logic [10:0] exp_q[$];
    int nxt;
    int cnt[3];

    lcd_msg_scheduler #(
        .LINE_LEN   (16),
        .LINE1_ADDR (7'h00),
        .LINE2_ADDR (7'h40)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .p1win     (p1win),
        .p2win     (p2win),
        .cmd_valid (cmd_valid),
        .cmd_rs    (cmd_rs),
        .cmd_data  (cmd_data),
        .cmd_rdy   (cmd_rdy),
        .busy      (busy),
        .grant     (grant),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference model: one message for player p as {grant, rs, byte} entries
    task automatic exp_msg(input int p);
        logic [1:0] g;
        string l1;
        g  = (p == 1) ? 2'b01 : 2'b10;
        l1 = $sformatf("PLAYER %0d WINS!  ", p);
        exp_q.push_back({g, 1'b0, 8'h01});
        exp_q.push_back({g, 1'b0, 8'h80});
        for (int i = 0; i < 16; i++) exp_q.push_back({g, 1'b1, l1[i]});
`ifdef LCD_SCHED_SCORE_EN
        begin
            string l2;
            if (cnt[p] < 9) cnt[p]++;
            l2 = $sformatf("P1:%0d  P2:%0d      ", cnt[1], cnt[2]);
            exp_q.push_back({g, 1'b0, 8'hC0});
            for (int i = 0; i < 16; i++) exp_q.push_back({g, 1'b1, l2[i]});
        end
`endif
        nxt = 3 - p;
    endtask

    // Model of which messages a set of simultaneous events produces
    task automatic exp_events(input bit a, input bit b);
        if (a && b) begin
            int first;
            first = nxt;
            exp_msg(first);
            exp_msg(3 - first);
        end else if (a) begin
            exp_msg(1);
        end else if (b) begin
            exp_msg(2);
        end
    endtask

    task automatic compare(input string tag);
        chk({tag, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_xfer%0d", tag, i), got[i], exp_q[i]);
        got.delete();
        exp_q.delete();
    endtask

    task automatic trig(input bit a, input bit b);
        @(negedge clk);
        p1win = ~a;
        p2win = ~b;
    endtask

    // Drives cmd_rdy, records transfers and checks handshake stability
    task automatic run(input int n_msgs, input int rdy_mode, input bit pulse_p1, input int budget);
        int cyc;
        int done_seen;
        bit stall;
        logic [8:0] last;
        cyc = 0;
        done_seen = 0;
        stall = 1'b0;
        last = '0;
        while (cyc < budget && !(done_seen == n_msgs && !busy)) begin
            if (stall) chk("stall_hold", {cmd_valid, cmd_rs, cmd_data}, {1'b1, last});
            if (done) done_seen++;
            case (rdy_mode)
                0:       cmd_rdy = 1'b1;
                1:       cmd_rdy = cyc[0];
                default: cmd_rdy = 1'($urandom_range(0, 1));
            endcase
            if (pulse_p1 && cyc >= 6 && cyc < 14) p1win = cyc[1];
            else if (cyc >= 2) p1win = 1'b1;
            if (cyc >= 2) p2win = 1'b1;
            if (cmd_valid && cmd_rdy) got.push_back({grant, cmd_rs, cmd_data});
            stall = cmd_valid && !cmd_rdy;
            last  = {cmd_rs, cmd_data};
            @(negedge clk);
            cyc++;
        end
        chk("run_in_budget", 32'(cyc < budget), 32'd1);
        chk("done_count", done_seen, n_msgs);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_valid", cmd_valid, 1'b0);
        chk("rst_busy",  busy,      1'b0);
        chk("rst_grant", grant,     2'b00);
        chk("rst_done",  done,      1'b0);
        chk("rst_data",  cmd_data,  8'h00);
        @(negedge clk);
        rst = 1'b1;
        nxt = 1;
        cnt[1] = 0;
        cnt[2] = 0;
    endtask

    initial begin
        int lat;
        int n;
        bit a, b;
        rst = 1'b0;
        p1win = 1'b1;
        p2win = 1'b1;
        cmd_rdy = 1'b0;
        nxt = 1;
        cnt[0] = 0; cnt[1] = 0; cnt[2] = 0;
        #1;
        chk("init_valid", cmd_valid, 1'b0);
        chk("init_busy",  busy,      1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_no_spurious", busy, 1'b0);

        // Single P1 message with zero-wait ready; also event-to-busy latency
        trig(1'b1, 1'b0);
        exp_events(1'b1, 1'b0);
        lat = 0;
        while (!busy && lat < 10) begin
            @(negedge clk);
            lat++;
            if (lat == 1) p1win = 1'b1;
        end
        chk("busy_latency", lat, 3);
        chk("grant_at_start", grant, 2'b01);
        run(1, 0, 1'b0, 200);
        compare("p1_rdy1");
        chk("grant_cleared", grant, 2'b00);

        // Same message with ready toggling every other cycle
        trig(1'b1, 1'b0);
        exp_events(1'b1, 1'b0);
        run(1, 1, 1'b0, 300);
        compare("p1_toggle");

        // Simultaneous events right after reset: P1 first, then P2
        do_reset();
        trig(1'b1, 1'b1);
        exp_events(1'b1, 1'b1);
        run(2, 0, 1'b0, 300);
        chk("simul_first_owner",  got[0][10:9],  2'b01);
        chk("simul_second_owner", got[$][10:9],  2'b10);
        compare("simul");

        // Repeated P1 events during its own message: exactly one rerun
        trig(1'b1, 1'b0);
        exp_msg(1);
        exp_msg(1);
        run(2, 0, 1'b1, 300);
        compare("coalesce");

        // Reset in the middle of line 1: immediate zero outputs, no done
        do_reset();
        trig(1'b0, 1'b1);
        cmd_rdy = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 5; c++) begin
            @(negedge clk);
            p2win = 1'b1;
            if (cmd_valid && cmd_rdy) n++;
        end
        chk("midl1_reached", n, 5);
        chk("midl1_rs", cmd_rs, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_valid", cmd_valid, 1'b0);
        chk("midrst_busy",  busy,      1'b0);
        chk("midrst_grant", grant,     2'b00);
        chk("midrst_rs",    cmd_rs,    1'b0);
        chk("midrst_data",  cmd_data,  8'h00);
        n = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) n++;
        end
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done || busy) n++;
        end
        chk("midrst_no_done", n, 0);
        nxt = 1;
        cnt[1] = 0;
        cnt[2] = 0;
        trig(1'b0, 1'b1);
        exp_events(1'b0, 1'b1);
        run(1, 0, 1'b0, 200);
        compare("after_rst_p2");

        // Random events and random ready behaviour
        for (int it = 0; it < 8; it++) begin
            int sel;
            int mode;
            sel  = int'($urandom_range(1, 3));
            mode = int'($urandom_range(0, 2));
            a = sel[0];
            b = sel[1];
            trig(a, b);
            exp_events(a, b);
            run((a && b) ? 2 : 1, mode, 1'b0, 600);
            compare($sformatf("rand%0d", it));
        end

`ifdef LCD_SCHED_SCORE_EN
        // Eleven P2 wins: the P2 counter saturates at 9
        do_reset();
        for (int k = 0; k < 11; k++) begin
            trig(1'b0, 1'b1);
            exp_events(1'b0, 1'b1);
            run(1, 0, 1'b0, 200);
            if (k == 10) begin
                string fin;
                logic [7:0] ch;
                fin = "P1:0  P2:9      ";
                for (int i = 0; i < 16; i++) begin
                    ch = fin[i];
                    chk($sformatf("sat_line2_%0d", i), got[got.size() - 16 + i][7:0], ch);
                end
            end
            compare($sformatf("score%0d", k));
        end
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
